// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared constants for the four-digit seven-segment scan controller:
// segment glyphs (bit6=a .. bit0=g, active-high), scan state encoding,
// and the leading-zero suppression helper.
package seven_segment_scan_controller_pkg;

   localparam int CNT_W = 16;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   // Marks digits that are zero and sit above the first non-zero digit,
   // scanning from the thousands digit down. The ones digit is never marked.
   function automatic logic [3:0] lead_zero_mask(input logic [15:0] value,
                                                 input logic        enable);
      logic [3:0] mask;
      mask    = 4'b0000;
      mask[3] = enable && (value[15:12] == 4'd0);
      mask[2] = mask[3] && (value[11:8] == 4'd0);
      mask[1] = mask[2] && (value[7:4] == 4'd0);
      return mask;
   endfunction

endpackage

// File: rtl/seven_segment_scan_controller_bcd_digit_decoder.sv
// Combinational BCD nibble to seven-segment glyph decoder.
// Non-decimal nibbles (A..F) produce a dark digit.
module bcd_digit_decoder
   import seven_segment_scan_controller_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   // Glyph lookup
   always_comb begin
      pattern = SEG_BLANK;
      case (nibble)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_BLANK | slot cycles 0..BLANK_CYCLES-1, all digits and segments off
//   ST_DRIVE | remaining slot cycles, active digit driven with its glyph
//
// New values are taken through a one-deep pending register and only move
// into the display register at the end of a frame, so a frame never shows
// a mix of old and new digits. Outputs are registered from next-state
// values so that they line up with the slot counter.
// SCAN_DIVIDE must be 4..65535; BLANK_CYCLES must be 1..SCAN_DIVIDE-1.
module seven_segment_scan_controller
   import seven_segment_scan_controller_pkg::*;
#(
   parameter int unsigned SCAN_DIVIDE  = 1000,
   parameter int unsigned BLANK_CYCLES = 50
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        Load,
   input  logic [15:0] Value,
   input  logic        Blank_Leading_Zeros,
   output logic        Ready,
   output logic [6:0]  Segments,
   output logic [3:0]  Digit_Enable,
   output logic        Frame_Done
);

   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SCAN_DIVIDE - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES - 1);

   scan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       digit_q, digit_d;
   logic [15:0]      disp_q, disp_d;
   logic [15:0]      pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       en_q, en_d;
   logic             frame_done_q, frame_done_d;

   logic             wrap;
   logic [3:0]       nibble_sel;
   logic [6:0]       glyph;
   logic [3:0]       sup_mask;

   assign wrap = (cnt_q == LAST_CNT);

   // Scan state: blank window at slot start, drive for the rest of the slot
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BLANK: if (cnt_q == BLANK_END) state_d = ST_DRIVE;
         ST_DRIVE: if (wrap)               state_d = ST_BLANK;
         default:                          state_d = ST_BLANK;
      endcase
   end

   // Slot counter, digit index and the load/display handshake
   always_comb begin
      cnt_d      = wrap ? '0 : cnt_q + 1'b1;
      digit_d    = wrap ? digit_q + 2'd1 : digit_q;
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (frame_done_q && pend_vld_q) begin
         disp_d     = pend_q;
         pend_vld_d = 1'b0;
      end else if (Load && !pend_vld_q) begin
         pend_d     = Value;
         pend_vld_d = 1'b1;
      end
   end

   assign nibble_sel = disp_d[{digit_d, 2'b00} +: 4];
   assign sup_mask   = lead_zero_mask(disp_d, Blank_Leading_Zeros);

   bcd_digit_decoder u_decoder (
      .nibble  (nibble_sel),
      .pattern (glyph)
   );

   // Next values for the registered display outputs
   always_comb begin
      seg_d        = SEG_BLANK;
      en_d         = 4'b0000;
      frame_done_d = (digit_d == 2'd3) && (cnt_d == LAST_CNT);
      if (state_d == ST_DRIVE) begin
         en_d = 4'b0001 << digit_d;
         if (!sup_mask[digit_d]) seg_d = glyph;
      end
   end

   // State and output registers; reset drops any pending value
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= ST_BLANK;
         cnt_q        <= '0;
         digit_q      <= 2'd0;
         disp_q       <= 16'h0000;
         pend_q       <= 16'h0000;
         pend_vld_q   <= 1'b0;
         seg_q        <= SEG_BLANK;
         en_q         <= 4'b0000;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         digit_q      <= digit_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pend_vld_q   <= pend_vld_d;
         seg_q        <= seg_d;
         en_q         <= en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign Ready        = ~pend_vld_q;
   assign Segments     = seg_q;
   assign Digit_Enable = en_q;
   assign Frame_Done   = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for the seven-segment scan controller. A reference model advances
// one clock cycle at a time from the documented rules (slot position,
// frame position, whole-value leading-zero test) and queues the expected
// outputs; a monitor pops and compares them once per cycle.
module tb_seven_segment_scan_controller;

   localparam int SD    = 8;
   localparam int BC    = 2;
   localparam int FRAME = 4 * SD;

   logic        Clock               = 1'b0;
   logic        Reset_n             = 1'b0;
   logic        Load                = 1'b0;
   logic [15:0] Value               = 16'h0000;
   logic        Blank_Leading_Zeros = 1'b0;
   logic        Ready;
   logic [6:0]  Segments;
   logic [3:0]  Digit_Enable;
   logic        Frame_Done;

   typedef struct {
      int         cyc;
      logic [6:0] seg;
      logic [3:0] en;
      logic       rdy;
      logic       fd;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   int          m_c;
   logic [15:0] m_disp;
   logic [15:0] m_pend;
   logic        m_pv;
   logic        m_blz_prev;

   logic [15:0] r_val;
   logic        r_ld;
   logic        r_blz;

   seven_segment_scan_controller #(
      .SCAN_DIVIDE  (SD),
      .BLANK_CYCLES (BC)
   ) dut (
      .Clock               (Clock),
      .Reset_n             (Reset_n),
      .Load                (Load),
      .Value               (Value),
      .Blank_Leading_Zeros (Blank_Leading_Zeros),
      .Ready               (Ready),
      .Segments            (Segments),
      .Digit_Enable        (Digit_Enable),
      .Frame_Done          (Frame_Done)
   );

   always #5 Clock = ~Clock;

   function automatic logic [6:0] glyph(input int n);
      case (n)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   // Expected outputs for cycle c given the display value and the
   // blank-leading-zeros input seen during the previous cycle.
   function automatic exp_t expect_at(input int c, input logic [15:0] disp,
                                      input logic pv, input logic blz);
      exp_t e;
      int   pos;
      int   dig;
      int   upper;
      pos   = c % SD;
      dig   = (c / SD) % 4;
      e.cyc = c;
      e.rdy = !pv;
      e.fd  = ((c % FRAME) == FRAME - 1);
      e.seg = 7'b0000000;
      e.en  = 4'b0000;
      if (pos >= BC) begin
         e.en  = 4'(1 << dig);
         upper = int'(disp) >> (4 * dig);
         if (!(blz && dig > 0 && upper == 0)) e.seg = glyph(upper % 16);
      end
      return e;
   endfunction

   function automatic void chk(input string name, input logic [15:0] act,
                               input logic [15:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got %h want %h", name, act, want);
      end
   endfunction

   // Advance one cycle: fold the inputs of the cycle that just ended into
   // the model, drive the new inputs, and queue the new cycle's outputs.
   task automatic next_cycle(input logic ld, input logic [15:0] val, input logic blz);
      @(posedge Clock);
      if ((m_c % FRAME) == FRAME - 1 && m_pv) begin
         m_disp = m_pend;
         m_pv   = 1'b0;
      end else if (Load && !m_pv) begin
         m_pend = Value;
         m_pv   = 1'b1;
      end
      m_blz_prev = Blank_Leading_Zeros;
      m_c++;
      #1;
      Load                = ld;
      Value               = val;
      Blank_Leading_Zeros = blz;
      sb.push_back(expect_at(m_c, m_disp, m_pv, m_blz_prev));
   endtask

   task automatic idle(input int n);
      repeat (n) next_cycle(1'b0, 16'h0000, Blank_Leading_Zeros);
   endtask

   // Assert reset mid-cycle, check the outputs clear at once, then release.
   task automatic apply_reset();
      @(posedge Clock);
      #2;
      Reset_n = 1'b0;
      Load    = 1'b0;
      Value   = 16'h0000;
      #1;
      chk("rst_seg", 16'(Segments), 16'h0000);
      chk("rst_en", 16'(Digit_Enable), 16'h0000);
      chk("rst_rdy", 16'(Ready), 16'h0001);
      chk("rst_fd", 16'(Frame_Done), 16'h0000);
      repeat (2) @(posedge Clock);
      #2;
      Reset_n    = 1'b1;
      m_c        = 0;
      m_disp     = 16'h0000;
      m_pend     = 16'h0000;
      m_pv       = 1'b0;
      m_blz_prev = Blank_Leading_Zeros;
      sb.push_back(expect_at(0, m_disp, m_pv, m_blz_prev));
   endtask

   task automatic load_when_ready(input logic [15:0] val, input logic blz);
      int n;
      n = 0;
      while (m_pv && n < 2 * FRAME) begin
         next_cycle(1'b0, 16'h0000, blz);
         n++;
      end
      chk("ready_wait", 16'(m_pv), 16'h0000);
      next_cycle(1'b1, val, blz);
      next_cycle(1'b0, 16'h0000, blz);
   endtask

   // Monitor: compare the DUT against the queued expectation each cycle
   initial begin
      forever begin
         @(negedge Clock);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++;
            if (Segments !== mon_e.seg || Digit_Enable !== mon_e.en ||
                Ready !== mon_e.rdy || Frame_Done !== mon_e.fd) begin
               bad++;
               $display("FAIL scan_out cyc=%0d seg got %b want %b en got %b want %b rdy got %b want %b fd got %b want %b",
                        mon_e.cyc, Segments, mon_e.seg, Digit_Enable, mon_e.en,
                        Ready, mon_e.rdy, Frame_Done, mon_e.fd);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      // Idle frames after reset: all digits show 0
      apply_reset();
      idle(70);

      // Load 0x1234 at cycle 5; the load at cycle 10 is ignored
      apply_reset();
      idle(4);
      next_cycle(1'b1, 16'h1234, 1'b0);
      idle(4);
      next_cycle(1'b1, 16'h9999, 1'b0);
      idle(60);

      // Leading-zero suppression and non-decimal nibbles
      load_when_ready(16'h0045, 1'b1);
      idle(80);
      load_when_ready(16'h0000, 1'b1);
      idle(80);
      load_when_ready(16'h00A0, 1'b0);
      idle(80);

      // Load accepted on the frame-done cycle itself
      begin
         int n;
         n = 0;
         while (!((m_c % FRAME) == FRAME - 2 && !m_pv) && n < 4 * FRAME) begin
            idle(1);
            n++;
         end
         chk("fd_align", 16'(m_c % FRAME), 16'(FRAME - 2));
         next_cycle(1'b1, 16'h0807, 1'b1);
         idle(80);
      end

      // Reset during the drive window with a pending value
      apply_reset();
      idle(4);
      next_cycle(1'b1, 16'h5678, 1'b0);
      idle(14);
      apply_reset();
      idle(70);

      // Randomized loads, values and suppression control
      for (int i = 0; i < 900; i++) begin
         r_val = 16'($urandom);
         for (int k = 0; k < 4; k++)
            if ($urandom_range(0, 1) == 0) r_val[4*k +: 4] = 4'd0;
         r_ld  = ($urandom_range(0, 5) == 0);
         r_blz = Blank_Leading_Zeros;
         if ($urandom_range(0, 29) == 0) r_blz = ~r_blz;
         next_cycle(r_ld, r_val, r_blz);
      end

      @(negedge Clock);
      #1;
      chk("sb_drain", 16'(sb.size()), 16'h0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seven_segment_scan_controller.md
SEVEN_SEGMENT_SCAN_CONTROLLER -- requirements
Module: seven_segment_scan_controller

Interface
REQ-001 The module SHALL have parameter SCAN_DIVIDE, default 1000: clock cycles per digit slot; legal range 4..65535.
REQ-002 The module SHALL have parameter BLANK_CYCLES, default 50: anti-ghosting dead time at the start of each slot; must be at least 1 and less than SCAN_DIVIDE.
REQ-003 The module SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port Reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port Load, input, 1 bit: request to accept a new display value.
REQ-006 The module SHALL have port Value, input, 16 bits: four packed BCD digits; [3:0] is ones, [15:12] is thousands.
REQ-007 The module SHALL have port Blank_Leading_Zeros, input, 1 bit: when high, suppresses leading zero digits.
REQ-008 The module SHALL have port Ready, output, 1 bit: high when a Load will be accepted.
REQ-009 The module SHALL have port Segments, output, 7 bits: segment pattern for the active digit, bit6=a through bit0=g, active-high.
REQ-010 The module SHALL have port Digit_Enable, output, 4 bits: one-hot active-high digit select; bit0 is the ones digit.
REQ-011 The module SHALL have port Frame_Done, output, 1 bit: one-cycle pulse on the last cycle of the digit-3 slot.

Function
REQ-012 A slot counter SHALL count 0..SCAN_DIVIDE-1 and wrap to 0; on wrap the digit index SHALL advance 0→1→2→3→0.
REQ-013 State BLANK SHALL cover slot cycles 0..BLANK_CYCLES-1, with Digit_Enable=0000 and Segments=0000000.
REQ-014 State DRIVE SHALL cover slot cycles BLANK_CYCLES..SCAN_DIVIDE-1, with Digit_Enable one-hot at the digit index and Segments equal to the decoded digit.
REQ-015 The state machine SHALL transition BLANK→DRIVE when the counter equals BLANK_CYCLES-1, and DRIVE→BLANK on counter wrap.
REQ-016 Decoding SHALL use these patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-017 Nibbles A..F SHALL decode to 0000000.
REQ-018 Segments and Digit_Enable SHALL be registered outputs with no combinational path from any input.
REQ-019 Handshake: Load sampled high while Ready=1 SHALL capture Value into a pending register, and Ready SHALL fall on the next cycle.
REQ-020 Load while Ready=0 SHALL be ignored; the pending value is unchanged.
REQ-021 On the Frame_Done cycle with a pending value present, the pending value SHALL copy to the display register and Ready SHALL rise on the next cycle, so there is no tearing within a frame.
REQ-022 Load accepted on the Frame_Done cycle itself SHALL be held until the following frame boundary.
REQ-023 Leading-zero suppression SHALL be evaluated from the display register, most significant digit first.
REQ-024 With Blank_Leading_Zeros=1, each zero digit above the first non-zero digit SHALL drive Segments=0000000 while Digit_Enable is still asserted.
REQ-025 Digit 0 SHALL never be suppressed.
REQ-026 Blank_Leading_Zeros SHALL be sampled every cycle, with no latching.
REQ-027 The display register SHALL be updated only at a frame boundary.

Reset
REQ-028 While Reset_n=0, asynchronously: counter=0, digit index=0, state=BLANK, display register=0x0000, pending empty, Ready=1, Segments=0000000, Digit_Enable=0000, Frame_Done=0.
REQ-029 Reset asserted mid-frame or mid-handshake SHALL discard any pending value.
REQ-030 The first clock after Reset_n rises SHALL be slot cycle 0 of digit 0.

Structure
REQ-031 A shared package/include SHALL hold the ten segment pattern constants, the blank pattern, and the BLANK/DRIVE state encodings.
REQ-032 One sub-module, bcd_digit_decoder (4-bit nibble in, 7-bit pattern out, combinational), SHALL be instantiated once on the muxed digit.
REQ-033 The slot counter width SHALL be 16 bits.

Verification
All scenarios use SCAN_DIVIDE=8 and BLANK_CYCLES=2.
REQ-034 Release reset, no Load → 32-cycle frame; each slot is 2 cycles of Enable 0000, then 6 cycles of 0001/0010/0100/1000 with Segments 1111110; Frame_Done pulses at cycles 31, 63, ...
REQ-035 Load with Value=0x1234 at cycle 5 → Ready=0 from cycle 6; frame 0 still shows 0000; from cycle 32, digit0=0110011, digit1=1111001, digit2=1101101, digit3=0110000; Ready=1 at cycle 32.
REQ-036 After Load 0x1234 at cycle 5, Load 0x9999 at cycle 10 → ignored; frame 1 shows 1234.
REQ-037 Load 0x0045 with Blank_Leading_Zeros=1 → digits 3 and 2 show 0000000 with Enable asserted, digit1=0110011, digit0=1011011; Load 0x0000 → digit0=1111110, others blank.
REQ-038 Load 0x00A0 → digit1 Segments=0000000; the other digits show 1111110.
REQ-039 Reset_n low at cycle 20 (DRIVE, pending present) → the same cycle shows Segments=0, Enable=0, Ready=1; after release, the display shows 0000.
